// File: rtl/softmax_row_stream.sv
`timescale 1ns/1ps
// softmax_row_stream
// Row-wise integer softmax. Buffers one row of signed Q4.4 elements, then
// computes base-2 exponentials relative to the row max (16-entry LUT plus
// shift), takes one sequential reciprocal of the row sum, and streams out
// unsigned Q0.8 probabilities, one multiply per element.
//
// Ports
//   clk_p      clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input element valid
//   in_ready   input accept, high only while loading a row
//   in_data    signed Q4.4 element
//   out_valid  output element valid (registered)
//   out_ready  downstream accept
//   out_data   unsigned Q0.8 probability (registered, saturated at 255)
//   out_last   final element of the row (registered)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_LOAD  | accept ROW_LEN elements into row_buf, track running max
// S_EXP   | one element per cycle: e = LUT[d[3:0]] >> d[7:4], accumulate
// S_RECIP | 25-step restoring divide, recip = floor(2^24 / sum)
// S_OUT   | present (e * recip) >> 16 per element, advance on handshake
module softmax_row_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_LEN    = 64
) (
    input  logic                  clk_p,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic                  out_last
);

    localparam int IDX_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int SUM_W = 9 + $clog2(ROW_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);

    typedef enum logic [1:0] {S_LOAD, S_EXP, S_RECIP, S_OUT} state_t;

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic signed [7:0]        max_val;
    logic [SUM_W-1:0]         sum;
    logic [SUM_W-1:0]         rem;
    logic [16:0]              recip;
    logic [4:0]               div_cnt;

    logic signed [7:0]        row_buf [ROW_LEN];
    logic [8:0]               ebuf    [ROW_LEN];

    logic                     accept;
    logic [7:0]               diff;
    logic [8:0]               exp_val;
    logic                     div_bit;
    logic [SUM_W:0]           rem_shift;
    logic                     rem_ge;
    logic [IDX_W-1:0]         sel;
    logic [9:0]               p_full;
    logic [7:0]               p_sat;

    function automatic logic [8:0] exp_lut(input logic [3:0] k);
        case (k)
            4'd0:    exp_lut = 9'd256;
            4'd1:    exp_lut = 9'd245;
            4'd2:    exp_lut = 9'd235;
            4'd3:    exp_lut = 9'd225;
            4'd4:    exp_lut = 9'd215;
            4'd5:    exp_lut = 9'd206;
            4'd6:    exp_lut = 9'd197;
            4'd7:    exp_lut = 9'd189;
            4'd8:    exp_lut = 9'd181;
            4'd9:    exp_lut = 9'd173;
            4'd10:   exp_lut = 9'd166;
            4'd11:   exp_lut = 9'd159;
            4'd12:   exp_lut = 9'd152;
            4'd13:   exp_lut = 9'd146;
            4'd14:   exp_lut = 9'd140;
            default: exp_lut = 9'd134;
        endcase
    endfunction

    assign in_ready = (state == S_LOAD);
    assign accept   = in_valid && in_ready;

    // max is never below any element, so the 8-bit difference cannot wrap
    assign diff    = 8'($unsigned(max_val) - $unsigned(row_buf[idx]));
    assign exp_val = exp_lut(diff[3:0]) >> diff[7:4];

    // dividend 2^24 has only its MSB set; it enters on the first step
    assign div_bit   = (div_cnt == 5'd24);
    assign rem_shift = {rem, div_bit};
    assign rem_ge    = (rem_shift >= {1'b0, sum});

    // while an element is showing, the next register load is for idx+1
    assign sel    = out_valid ? idx + IDX_W'(1) : idx;
    assign p_full = 10'((26'(ebuf[sel]) * 26'(recip)) >> 16);
    assign p_sat  = (p_full > 10'd255) ? 8'hFF : p_full[7:0];

    always_ff @(posedge clk_p) begin
        if (accept) begin
            row_buf[idx] <= $signed(in_data);
        end
        if (state == S_EXP) begin
            ebuf[idx] <= exp_val;
        end
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LOAD;
            idx       <= '0;
            max_val   <= '0;
            sum       <= '0;
            rem       <= '0;
            recip     <= '0;
            div_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        if (idx == '0 || $signed(in_data) > max_val) begin
                            max_val <= $signed(in_data);
                        end
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            sum   <= '0;
                            state <= S_EXP;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                S_EXP: begin
                    sum <= sum + SUM_W'(exp_val);
                    if (idx == LAST_IDX) begin
                        idx     <= '0;
                        rem     <= '0;
                        recip   <= '0;
                        div_cnt <= 5'd24;
                        state   <= S_RECIP;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_RECIP: begin
                    rem   <= rem_ge ? SUM_W'(rem_shift - {1'b0, sum})
                                    : SUM_W'(rem_shift);
                    recip <= {recip[15:0], rem_ge};
                    if (div_cnt == 5'd0) begin
                        state <= S_OUT;
                    end else begin
                        div_cnt <= div_cnt - 5'd1;
                    end
                end
                S_OUT: begin
                    if (!out_valid) begin
                        out_data  <= p_sat;
                        out_last  <= (idx == LAST_IDX);
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            idx       <= '0;
                            state     <= S_LOAD;
                        end else begin
                            idx      <= idx + IDX_W'(1);
                            out_data <= p_sat;
                            out_last <= (idx + IDX_W'(1) == LAST_IDX);
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_row_stream.sv
`timescale 1ns/1ps
module tb_softmax_row_stream;

    localparam int ROW_LEN = 4;

    logic       clk_p = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;

    softmax_row_stream #(.DATA_WIDTH(8), .ROW_LEN(ROW_LEN)) dut (
        .clk_p     (clk_p),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk_p = ~clk_p;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic signed [7:0] stim [ROW_LEN];
    int   bp_mode = 0;
    int   rdy_cnt = 0;
    int   n_out = 0;

    logic       stalled = 1'b0;
    logic [7:0] held_data = 8'd0;
    logic       held_last = 1'b0;

    int lut_tab [16] = '{256, 245, 235, 225, 215, 206, 197, 189,
                         181, 173, 166, 159, 152, 146, 140, 134};

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // reference: softmax rules evaluated with plain integer arithmetic
    task automatic model_row();
        int mx, d, sum, r, p;
        int e [ROW_LEN];
        exp_t x;
        mx = stim[0];
        for (int i = 1; i < ROW_LEN; i++) if (int'(stim[i]) > mx) mx = stim[i];
        sum = 0;
        for (int i = 0; i < ROW_LEN; i++) begin
            d    = mx - int'(stim[i]);
            e[i] = lut_tab[d % 16] >> (d / 16);
            sum += e[i];
        end
        r = (1 << 24) / sum;
        for (int i = 0; i < ROW_LEN; i++) begin
            p = (e[i] * r) >> 16;
            if (p > 255) p = 255;
            x.data = 8'(p);
            x.last = (i == ROW_LEN - 1);
            exp_q.push_back(x);
        end
    endtask

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk_p);
            #1;
            case (bp_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (rdy_cnt % 4 == 0) || (rdy_cnt % 4 == 3);
                    rdy_cnt++;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_p);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, held_data);
                    check("stall_last", out_last, held_last);
                end
                if (out_valid) check("busy_in_ready", in_ready, 0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output actual=%0d required=none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_last", out_last, e.last);
                        n_out++;
                    end
                end
                stalled   = out_valid && !out_ready;
                held_data = out_data;
                held_last = out_last;
            end
        end
    end

    task automatic send_row(input bit lat_check, input bit hold_valid);
        bit accepted;
        int n, lowcnt;
        model_row();
        for (int i = 0; i < ROW_LEN; i++) begin
            in_data  = stim[i];
            in_valid = 1'b1;
            accepted = 1'b0;
            for (int w = 0; w < 500 && !accepted; w++) begin
                @(negedge clk_p);
                if (in_ready) begin
                    @(posedge clk_p);
                    #1;
                    accepted = 1'b1;
                end
            end
            if (!accepted) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=0 required=1");
                in_valid = 1'b0;
                return;
            end
        end
        if (!hold_valid) in_valid = 1'b0;
        check("in_ready_after_row", in_ready, 0);
        if (lat_check) begin
            n = 0;
            lowcnt = 0;
            while (!out_valid && n < 300) begin
                @(posedge clk_p);
                #1;
                n++;
                if (!in_ready) lowcnt++;
            end
            check("first_valid_latency", n, ROW_LEN + 26);
            check("in_ready_low_cycles", lowcnt, n);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            @(posedge clk_p);
            #1;
            n++;
        end
        check("drain_done", (exp_q.size() == 0 && !out_valid) ? 1 : 0, 1);
        check("in_ready_after_drain", in_ready, 1);
    endtask

    task automatic random_row();
        for (int i = 0; i < ROW_LEN; i++) stim[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic reset_after(input int cycles, input int want_valid);
        send_row(1'b0, 1'b0);
        repeat (cycles) @(posedge clk_p);
        #1;
        check("pre_reset_valid", out_valid, want_valid);
        rst_n = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        exp_q.delete();
        @(posedge clk_p);
        #2;
        rst_n = 1'b1;
        @(posedge clk_p);
        #1;
        check("post_reset_in_ready", in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int outs_before;
        rst_n = 1'b0;
        repeat (3) @(posedge clk_p);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        rst_n = 1'b1;
        @(posedge clk_p);
        #1;

        bp_mode = 0;
        stim = '{8'sd16, 8'sd0, 8'sd0, 8'sd0};
        send_row(1'b1, 1'b0);
        wait_drain();

        stim = '{8'sd127, -8'sd128, -8'sd128, -8'sd128};
        send_row(1'b1, 1'b0);
        wait_drain();

        stim = '{8'sh10, 8'sh10, 8'sh10, 8'sh10};
        send_row(1'b1, 1'b0);
        wait_drain();

        bp_mode = 1;
        rdy_cnt = 0;
        random_row();
        send_row(1'b1, 1'b0);
        wait_drain();

        bp_mode = 0;
        random_row();
        send_row(1'b1, 1'b1);
        random_row();
        send_row(1'b1, 1'b0);
        wait_drain();

        bp_mode = 2;
        for (int r = 0; r < 8; r++) begin
            random_row();
            send_row(1'b1, ($urandom_range(0, 1) == 1));
        end
        in_valid = 1'b0;
        wait_drain();

        bp_mode = 0;
        random_row();
        reset_after(ROW_LEN + 10, 0);
        random_row();
        reset_after(ROW_LEN + 27, 1);
        stim = '{8'sd16, 8'sd0, 8'sd0, 8'sd0};
        outs_before = n_out;
        send_row(1'b1, 1'b0);
        wait_drain();
        check("fresh_row_outputs", n_out - outs_before, ROW_LEN);

        check("leftover_expected", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/softmax_row_stream.md
# softmax_row_stream

Row-wise integer softmax stage that sits directly downstream of the MAC stage. It consumes the signed 8-bit MAC result one row at a time over a valid/ready stream and returns each row normalised to unsigned Q0.8 probabilities. It uses a base-2 exponential approximation (16-entry LUT plus shift), one sequential reciprocal per row, and one multiply per element. Only one row is in flight at a time, held in an internal row buffer.

## Interface
- DATA_WIDTH, 8, element width. Fixed at 8; the LUT and the Q4.4 input format depend on it.
- ROW_LEN, 64, elements per row (the MAC OUTPUT_SHAPE_2 slice). Must be ≥ 2.
- clk_p  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  high only in LOAD.
- in_data  in  8  signed Q4.4 MAC output element.
- out_valid  out  1  output element valid.
- out_ready  in  1  downstream accept.
- out_data  out  8  unsigned Q0.8 probability (255 ≈ 1.0).
- out_last  out  1  high with the final element of a row.

## Operation
- FSM states: LOAD → EXP → RECIP → OUT → LOAD.
- Reset values: state = LOAD, all counters and max/sum/recip registers = 0, in_ready = 1, out_valid = 0, out_data = 0, out_last = 0.
- **LOAD**
  - On in_valid && in_ready: write in_data to buf[idx], idx++.
  - Running max: the first element of the row loads max; later elements update it with a signed compare.
  - After the ROW_LEN-th accept: idx = 0, go to EXP.
- **EXP** (one element per cycle)
  - d = max − buf[idx], 8-bit unsigned (range 0..255, no overflow).
  - e = LUT[d[3:0]] >> d[7:4], 9 bits unsigned.
  - LUT = 256,245,235,225,215,206,197,189,181,173,166,159,152,146,140,134.
  - Store e in ebuf[idx]. sum += e.
  - sum width is 9 + clog2(ROW_LEN); it cannot overflow.
  - sum ≥ 256 is guaranteed because the max element gives e = 256.
- **RECIP**
  - Restoring divider, one quotient bit per cycle, 25 cycles.
  - R = floor(2^24 / sum), 17 bits (≤ 65536).
- **OUT**
  - p = (ebuf[idx] × R) >> 16, 26-bit product, floor.
  - out_data = min(p, 255).
  - out_last = (idx == ROW_LEN−1).
  - Advance idx only on out_valid && out_ready.
  - After the last element is accepted: out_valid drops and the FSM returns to LOAD.
- in_data is ignored outside LOAD (in_ready = 0).
- Rows never overlap.

## Timing
- in_ready is combinational from state. It deasserts in the cycle after the ROW_LEN-th accept.
- Counting from the edge that accepts the last input as cycle 0:
  - EXP occupies cycles 1..ROW_LEN.
  - RECIP occupies cycles ROW_LEN+1..ROW_LEN+25.
  - out_valid first rises in cycle ROW_LEN+26.
- out_data and out_last are registered.
  - Under out_valid && !out_ready they hold stable.
  - With out_ready held high, one element is emitted per cycle with no bubbles.
- After the final output handshake, in_ready = 1 in the next cycle. Back-to-back rows therefore cost ROW_LEN+26 overhead cycles plus the stream time.
- Reset mid-operation, in any state: the partial row is discarded, out_valid drops immediately (asynchronous), and the FSM restarts in LOAD at idx 0.
- Simultaneous in_valid during OUT: not accepted; the upstream stage must hold its data.

## Test plan
- ROW_LEN=64, all elements equal (e.g. 0x10) → sum = 16384, R = 1024, every out_data = 4, out_last only on element 63.
- ROW_LEN=4, row [16,0,0,0] → sum = 640, R = 26214, outputs [102,51,51,51].
- ROW_LEN=4, row [127,−128,−128,−128] → d = 255 gives e = 0; sum = 256, R = 65536, outputs [255 (saturated),0,0,0].
- Backpressure: out_ready toggled 1-0-0-1 during the OUT stream → out_data/out_last stable while stalled, no element lost or duplicated, in_ready stays 0 until the final handshake.
- Two rows back to back with in_valid held high → in_ready low from the cycle after the 4th accept until after the 4th output handshake; first out_valid exactly ROW_LEN+26 cycles after the last accept; the second row's results are independent of the first.
- Assert rst_n low during RECIP and again during OUT → out_valid = 0 immediately, in_ready = 1 after release, a fresh row produces the correct results.
